// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Multicycle control unit for the ARM-subset processor. Each instruction is
//   sequenced through an FSM that shares one memory and one ALU. The NZCV
//   flags live here, and the condition field is evaluated in DECODE. Memory
//   wait states are honoured through MemReady. Retired instructions are
//   counted.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   Instr[19:0]     instruction bits [31:12] from the instruction register
//   ALUFlags[3:0]   {N,Z,C,V} produced by the ALU this cycle
//   MemReady        memory completes the access this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables (0 while reset high)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
//                   datapath steering
//   State[3:0]      current FSM state (debug)
//   InstrCount      retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALUCTRL_W = 4,
    parameter bit MEM_WAIT  = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [3:0]           State,
    output logic [CNT_W-1:0]     InstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

    // Instruction fields; the port carries bits [31:12], so bit k is Instr[k-12].
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit, u_bit, s_bit;
    logic [3:0] cmd, rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign i_bit     = Instr[13];
    assign cmd       = Instr[12:9];
    assign u_bit     = Instr[11];
    assign s_bit     = Instr[8];   // S for data processing, L for memory
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    logic [3:0]       state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With MEM_WAIT=0 every memory access completes in a single cycle.
    logic mem_rdy;
    assign mem_rdy = MEM_WAIT ? MemReady : 1'b1;

    // Condition evaluation against the stored flags {N,Z,C,V}.
    logic cond_ex;
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode. Unsupported commands execute as an ADD whose
    // result and flags are both discarded.
    logic [ALUCTRL_W-1:0] dp_ctl;
    logic                 dp_wb, dp_cmp, dp_arith;
    always_comb begin
        dp_ctl   = ALU_ADD;
        dp_wb    = 1'b0;
        dp_cmp   = 1'b0;
        dp_arith = 1'b0;
        case (cmd)
            4'b0100: begin dp_ctl = ALU_ADD; dp_wb = 1'b1; dp_arith = 1'b1; end
            4'b0010: begin dp_ctl = ALU_SUB; dp_wb = 1'b1; dp_arith = 1'b1; end
            4'b0000: begin dp_ctl = ALU_AND; dp_wb = 1'b1; end
            4'b1100: begin dp_ctl = ALU_ORR; dp_wb = 1'b1; end
            4'b1010: begin dp_ctl = ALU_SUB; dp_cmp = 1'b1; dp_arith = 1'b1; end
            default: ;
        endcase
    end

    logic pcw, irw, memw, regw;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        pcw        = 1'b0;
        irw        = 1'b0;
        memw       = 1'b0;
        regw       = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw       = mem_rdy;
                irw       = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures PC+8 for later use as R15.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!cond_ex || op == 2'b11) state_d = S_FETCH;
                else if (op == 2'b01)        state_d = S_MEMADR;
                else if (op == 2'b10)        state_d = S_BRANCH;
                else                         state_d = i_bit ? S_EXECI : S_EXECR;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_d    = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                pcw       = (rd == 4'd15);
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_ctl;
                if ((dp_wb || dp_cmp) && (s_bit || dp_cmp)) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
                end
                state_d = dp_wb ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                regw    = 1'b1;
                pcw     = (rd == 4'd15);
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw       = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // An instruction retires on every entry into FETCH from another state.
    assign cnt_d = (state_d == S_FETCH && state_q != S_FETCH) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write enables are suppressed for the whole reset window.
    assign PCWrite    = pcw  & ~reset;
    assign IRWrite    = irw  & ~reset;
    assign MemWrite   = memw & ~reset;
    assign RegWrite   = regw & ~reset;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign State      = state_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MEM_WAIT=1, CNT_W=32)
    logic        reset0, mr0;
    logic [19:0] instr0;
    logic [3:0]  flags_in;
    logic        PCWrite0, AdrSrc0, IRWrite0, MemWrite0, RegWrite0, ALUSrcA0;
    logic [1:0]  ResultSrc0, ALUSrcB0, ImmSrc0, RegSrc0;
    logic [3:0]  ALUControl0, State0;
    logic [31:0] InstrCount0;

    // Second instance (MEM_WAIT=0, CNT_W=4) for counter wrap
    logic        reset1, mr1;
    logic [19:0] instr1;
    logic        PCWrite1, AdrSrc1, IRWrite1, MemWrite1, RegWrite1, ALUSrcA1;
    logic [1:0]  ResultSrc1, ALUSrcB1, ImmSrc1, RegSrc1;
    logic [3:0]  ALUControl1, State1;
    logic [3:0]  InstrCount1;

    multicycle_controller #(.ALUCTRL_W(4), .MEM_WAIT(1'b1), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset0), .Instr(instr0), .ALUFlags(flags_in), .MemReady(mr0),
        .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .IRWrite(IRWrite0), .MemWrite(MemWrite0),
        .RegWrite(RegWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ALUControl(ALUControl0), .ImmSrc(ImmSrc0), .RegSrc(RegSrc0), .State(State0),
        .InstrCount(InstrCount0));

    multicycle_controller #(.ALUCTRL_W(4), .MEM_WAIT(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset1), .Instr(instr1), .ALUFlags(flags_in), .MemReady(mr1),
        .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .IRWrite(IRWrite1), .MemWrite(MemWrite1),
        .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
        .ALUControl(ALUControl1), .ImmSrc(ImmSrc1), .RegSrc(RegSrc1), .State(State1),
        .InstrCount(InstrCount1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model state
    logic [3:0]  m_flags;
    logic [31:0] m_cnt;

    // One expected cycle: state, {PCWrite,IRWrite,MemWrite,RegWrite},
    // {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}, MemReady and ALUFlags to drive.
    typedef struct packed {
        logic [3:0] st;
        logic [3:0] we;
        logic [9:0] mx;
        logic       mr;
        logic [3:0] af;
    } cyc_t;

    function automatic logic [9:0] mxv(input logic adr, input logic [1:0] rs, input logic a,
                                       input logic [1:0] b, input logic [3:0] ctl);
        return {adr, rs, a, b, ctl};
    endfunction

    function automatic cyc_t mk(input logic [3:0] st, input logic [3:0] we, input logic [9:0] mx,
                                input logic mr, input logic [3:0] af);
        cyc_t c;
        c.st = st; c.we = we; c.mx = mx; c.mr = mr; c.af = af;
        return c;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build the expected cycle list of one instruction from the architectural
    // rules, then drive it and compare every cycle. abort_at >= 0 asserts
    // reset in that cycle of the list instead of completing the instruction.
    task automatic run_instr(input logic [19:0] ins, input int fw, input int mw,
                             input logic [3:0] exf, input int abort_at);
        cyc_t q[$];
        logic [3:0] cond, cmd, rd, ctl;
        logic [1:0] op;
        logic ib, sb, ub, sup, cmp, arith;
        logic [9:0] mx_f;
        cond = ins[19:16]; op = ins[15:14]; ib = ins[13]; cmd = ins[12:9];
        ub = ins[11]; sb = ins[8]; rd = ins[3:0];
        sup   = (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'h0 || cmd == 4'hC || cmd == 4'hA);
        cmp   = (cmd == 4'hA);
        arith = (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA);
        case (cmd)
            4'h2, 4'hA: ctl = 4'd1;
            4'h0:       ctl = 4'd2;
            4'hC:       ctl = 4'd3;
            default:    ctl = 4'd0;
        endcase
        mx_f = mxv(1'b0, 2'b10, 1'b1, 2'b10, 4'd0);
        for (int k = 0; k < fw; k++) q.push_back(mk(4'd0, 4'b0000, mx_f, 1'b0, r4()));
        q.push_back(mk(4'd0, 4'b1100, mx_f, 1'b1, r4()));
        q.push_back(mk(4'd1, 4'b0000, mx_f, r1(), r4()));
        if (cond_ok(cond, m_flags) && op != 2'b11) begin
            case (op)
                2'b01: begin
                    q.push_back(mk(4'd2, 4'b0000, mxv(1'b0, 2'b00, 1'b0, 2'b01, ub ? 4'd0 : 4'd1), r1(), r4()));
                    if (sb) begin
                        for (int k = 0; k < mw; k++)
                            q.push_back(mk(4'd3, 4'b0000, mxv(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), 1'b0, r4()));
                        q.push_back(mk(4'd3, 4'b0000, mxv(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), 1'b1, r4()));
                        q.push_back(mk(4'd4, {rd == 4'hF, 3'b001}, mxv(1'b0, 2'b01, 1'b0, 2'b00, 4'd0), r1(), r4()));
                    end else begin
                        for (int k = 0; k < mw; k++)
                            q.push_back(mk(4'd5, 4'b0010, mxv(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), 1'b0, r4()));
                        q.push_back(mk(4'd5, 4'b0010, mxv(1'b1, 2'b00, 1'b0, 2'b00, 4'd0), 1'b1, r4()));
                    end
                end
                2'b10: q.push_back(mk(4'd9, 4'b1000, mxv(1'b0, 2'b10, 1'b0, 2'b01, 4'd0), r1(), r4()));
                default: begin
                    q.push_back(mk(ib ? 4'd7 : 4'd6, 4'b0000, mxv(1'b0, 2'b00, 1'b0, {1'b0, ib}, ctl), r1(), exf));
                    if (sup && !cmp)
                        q.push_back(mk(4'd8, {rd == 4'hF, 3'b001}, mxv(1'b0, 2'b00, 1'b0, 2'b00, 4'd0), r1(), r4()));
                    if (sup && (sb || cmp)) begin
                        m_flags[3:2] = exf[3:2];
                        if (arith) m_flags[1:0] = exf[1:0];
                    end
                end
            endcase
        end
        for (int k = 0; k < q.size(); k++) begin
            instr0 = ins; mr0 = q[k].mr; flags_in = q[k].af;
            if (k == abort_at) begin
                reset0 = 1'b1;
                @(negedge clk);
                chk_eq("abort_we", 32'({PCWrite0, IRWrite0, MemWrite0, RegWrite0}), 32'd0);
                @(posedge clk); #1;
                chk_eq("abort_state", 32'(State0), 32'd0);
                chk_eq("abort_memwrite", 32'(MemWrite0), 32'd0);
                chk_eq("abort_count", InstrCount0, 32'd0);
                reset0 = 1'b0;
                m_flags = 4'b0000;
                m_cnt = 32'd0;
                return;
            end
            @(negedge clk);
            chk_eq("state", 32'(State0), 32'(q[k].st));
            chk_eq("we", 32'({PCWrite0, IRWrite0, MemWrite0, RegWrite0}), 32'(q[k].we));
            chk_eq("mux", 32'({AdrSrc0, ResultSrc0, ALUSrcA0, ALUSrcB0, ALUControl0}), 32'(q[k].mx));
            chk_eq("imm_regsrc", 32'({ImmSrc0, RegSrc0}), 32'({op, op == 2'b01, op == 2'b10}));
            @(posedge clk); #1;
        end
        m_cnt = m_cnt + 32'd1;
        chk_eq("count", InstrCount0, m_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cond, cmd, rd;
        logic [1:0] op;
        logic ib, sb;
        logic [3:0] cmds [8];
        cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'h1, 4'h5, 4'hF};
        reset0 = 1'b1; reset1 = 1'b1; mr0 = 1'b1; mr1 = 1'b0;
        instr0 = 20'h0; instr1 = {4'hE, 2'b11, 14'h0}; flags_in = 4'h0;
        m_flags = 4'h0; m_cnt = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("reset_we", 32'({PCWrite0, IRWrite0, MemWrite0, RegWrite0}), 32'd0);
        chk_eq("reset_state", 32'(State0), 32'd0);
        chk_eq("reset_count", InstrCount0, 32'd0);
        @(posedge clk); #1;
        reset0 = 1'b0;

        // ADD R1,R2,R3
        run_instr({4'hE, 2'b00, 1'b0, 4'h4, 1'b0, 4'h2, 4'h1}, 0, 0, 4'hF, -1);
        // BEQ with flags still 0000 -> NOP
        run_instr({4'h0, 2'b10, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0}, 0, 0, 4'h0, -1);
        // SUBS setting Z, then BEQ taken, BNE skipped
        run_instr({4'hE, 2'b00, 1'b0, 4'h2, 1'b1, 4'h2, 4'h1}, 0, 0, 4'b0100, -1);
        run_instr({4'h0, 2'b10, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0}, 0, 0, 4'h0, -1);
        run_instr({4'h1, 2'b10, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0}, 0, 0, 4'h0, -1);
        // LDR with fetch and read wait states
        run_instr({4'hE, 2'b01, 1'b0, 4'hC, 1'b1, 4'h1, 4'h3}, 3, 2, 4'h0, -1);
        // STR with U=0 and write wait states
        run_instr({4'hE, 2'b01, 1'b0, 4'h8, 1'b0, 4'h1, 4'h3}, 0, 2, 4'h0, -1);
        // CMP, then ADD to R15, then CS / VC conditioned ops
        run_instr({4'hE, 2'b00, 1'b0, 4'hA, 1'b1, 4'h1, 4'h0}, 0, 0, 4'b0011, -1);
        run_instr({4'hE, 2'b00, 1'b1, 4'h4, 1'b0, 4'h1, 4'hF}, 1, 0, 4'h0, -1);
        run_instr({4'h2, 2'b00, 1'b0, 4'hC, 1'b0, 4'h1, 4'h2}, 0, 0, 4'h0, -1);
        run_instr({4'h7, 2'b00, 1'b0, 4'h4, 1'b0, 4'h1, 4'h2}, 0, 0, 4'h0, -1);
        // Reset during MEMWRITE while MemReady is low
        run_instr({4'hE, 2'b01, 1'b0, 4'hC, 1'b0, 4'h1, 4'h3}, 0, 2, 4'h0, 4);
        // Flags cleared by reset: EQ must not execute
        run_instr({4'h0, 2'b10, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0}, 0, 0, 4'h0, -1);

        for (int n = 0; n < 200; n++) begin
            cond = r1() ? 4'hE : r4();
            op   = 2'($urandom_range(0, 3));
            ib   = r1();
            cmd  = cmds[$urandom_range(0, 7)];
            sb   = r1();
            if (op == 2'b00 && cmd != 4'h4 && cmd != 4'h2 && cmd != 4'h0 && cmd != 4'hC && cmd != 4'hA)
                sb = 1'b0;
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : r4();
            run_instr({cond, op, ib, cmd, sb, r4(), rd}, $urandom_range(0, 3), $urandom_range(0, 3), r4(), -1);
        end

        // Counter wrap on the CNT_W=4, MEM_WAIT=0 instance with MemReady held low
        reset0 = 1'b1;
        reset1 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk_eq("u1_fetch_state", 32'(State1), 32'd0);
            chk_eq("u1_fetch_we", 32'({PCWrite1, IRWrite1, MemWrite1, RegWrite1}), 32'b1100);
            @(posedge clk); #1;
            @(negedge clk);
            chk_eq("u1_decode_state", 32'(State1), 32'd1);
            @(posedge clk); #1;
            chk_eq("u1_count", 32'(InstrCount1), 32'((k + 1) % 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
